aes_key_expand: RTL and testbench

AES_KEY_EXPAND -- requirements
Module: aes_key_expand

---
 rtl/aes_pkg.sv | 34 +++
 rtl/aes_key_step.sv | 41 ++++
 rtl/aes_key_expand.sv | 103 ++++++++++
 tb/tb_aes_key_expand.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule types, constants and byte helpers.
// The S-box table holds the same contents as the team's sbox.txt.
package aes_pkg;

   localparam int NR = 10;
   localparam int NK = 4;

   typedef logic [3:0] rnd_t;

   typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_e;

   localparam logic [7:0] RCON_INIT  = 8'h01;
   localparam logic [7:0] XTIME_POLY = 8'h1b;

   // Row-major S-box, entry 0x00 in the top byte
   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX_TBL[(255 - int'(b)) * 8 +: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
   endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule step: next round key from previous key and Rcon.
// AES_KEY_SYNC_SBOX_EN registers the four S-box outputs (one cycle of lookup latency).
module aes_key_step
   import aes_pkg::*;
(
`ifdef AES_KEY_SYNC_SBOX_EN
   input  logic         clk,
`endif
   input  logic [127:0] prev_key,
   input  logic [7:0]   rcon,
   output logic [127:0] next_key
);

   logic [31:0] rot_w;
   logic [31:0] sub_w;
   logic [31:0] acc;

   assign rot_w = {prev_key[23:0], prev_key[31:24]};

`ifdef AES_KEY_SYNC_SBOX_EN
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) sub_w[8*i +: 8] <= sbox(rot_w[8*i +: 8]);
   end
`else
   always_comb begin
      sub_w = '0;
      for (int i = 0; i < 4; i++) sub_w[8*i +: 8] = sbox(rot_w[8*i +: 8]);
   end
`endif

   // Each new word chains off the previous new word, starting from the SubWord/Rcon term
   always_comb begin
      next_key = '0;
      acc      = sub_w ^ {rcon, 24'h0};
      for (int i = 0; i < NK; i++) begin
         acc                       = acc ^ prev_key[127-32*i -: 32];
         next_key[127-32*i -: 32] = acc;
      end
   end

endmodule

// File: rtl/aes_key_expand.sv
// AES-128 key expansion into 11 stored round keys with a combinational read port.
// Build option AES_KEY_SYNC_SBOX_EN: registered S-boxes, two cycles per round step.
module aes_key_expand
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [127:0] key,
   input  logic [3:0]   rk_idx,
   output logic [127:0] rk,
   output logic         busy,
   output logic         keys_valid
);

   state_e       state_q, state_d;
   rnd_t         rnd_q, rnd_d;
   logic [7:0]   rcon_q, rcon_d;
   logic [127:0] keys_q [0:NR];
   logic [127:0] keys_d [0:NR];
   logic [127:0] prev_key, step_key;
   logic         step_wr;

`ifdef AES_KEY_SYNC_SBOX_EN
   logic phase_q, phase_d;
   assign step_wr = phase_q;

   aes_key_step u_step (.clk(clk), .prev_key(prev_key), .rcon(rcon_q), .next_key(step_key));
`else
   assign step_wr = 1'b1;

   aes_key_step u_step (.prev_key(prev_key), .rcon(rcon_q), .next_key(step_key));
`endif

   always_comb begin
      prev_key = '0;
      for (int i = 0; i < NR; i++) if (rnd_q == rnd_t'(i + 1)) prev_key = keys_q[i];
   end

   always_comb begin
      rk = '0;
      for (int i = 0; i <= NR; i++) if (rk_idx == rnd_t'(i)) rk = keys_q[i];
   end

   assign busy       = (state_q == EXPAND);
   assign keys_valid = (state_q == DONE);

   always_comb begin
      state_d = state_q;
      rnd_d   = rnd_q;
      rcon_d  = rcon_q;
      keys_d  = keys_q;
`ifdef AES_KEY_SYNC_SBOX_EN
      phase_d = phase_q;
`endif
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               keys_d[0] = key;
               rnd_d     = rnd_t'(1);
               rcon_d    = RCON_INIT;
               state_d   = EXPAND;
`ifdef AES_KEY_SYNC_SBOX_EN
               phase_d   = 1'b0;
`endif
            end
         end
         EXPAND: begin
`ifdef AES_KEY_SYNC_SBOX_EN
            phase_d = ~phase_q;
`endif
            if (step_wr) begin
               for (int i = 1; i <= NR; i++) if (rnd_q == rnd_t'(i)) keys_d[i] = step_key;
               rcon_d = xtime(rcon_q);
               rnd_d  = rnd_q + rnd_t'(1);
               if (rnd_q == rnd_t'(NR)) state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         rnd_q   <= '0;
         rcon_q  <= RCON_INIT;
         for (int i = 0; i <= NR; i++) keys_q[i] <= '0;
`ifdef AES_KEY_SYNC_SBOX_EN
         phase_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         rnd_q   <= rnd_d;
         rcon_q  <= rcon_d;
         for (int i = 0; i <= NR; i++) keys_q[i] <= keys_d[i];
`ifdef AES_KEY_SYNC_SBOX_EN
         phase_q <= phase_d;
`endif
      end
   end

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand using FIPS-197 key-schedule vectors.
module tb_aes_key_expand;

`ifdef AES_KEY_SYNC_SBOX_EN
   localparam int LAT = 21;
`else
   localparam int LAT = 11;
`endif

   localparam logic [127:0] KEY_A   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] A_RK1   = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] A_RK2   = 128'hf2c295f27a96b9435935807a7359f67f;
   localparam logic [127:0] A_RK10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] KEY_B   = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] B_RK1   = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
   localparam logic [127:0] B_RK10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [127:0] key;
   logic [3:0]   rk_idx;
   logic [127:0] rk;
   logic         busy;
   logic         keys_valid;

   int n_checks = 0;
   int n_fail   = 0;

   aes_key_expand dut (
      .clk(clk), .reset(reset), .start(start), .key(key), .rk_idx(rk_idx),
      .rk(rk), .busy(busy), .keys_valid(keys_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic read_rk(input int idx, output logic [127:0] val);
      rk_idx = 4'(idx);
      #1;
      val = rk;
   endtask

   // Drive start for one edge; on return that edge is the acceptance edge (+1 time unit)
   task automatic accept(input logic [127:0] k);
      start = 1'b1;
      key   = k;
      @(posedge clk);
      #1;
      start = 1'b0;
      key   = ~k;
   endtask

   // lat counts posedges with the acceptance edge as 1; poke_at>0 pulses start with key=0 mid-run
   task automatic run_to_done(input int poke_at, output int lat, output int busy_n);
      lat    = 1;
      busy_n = (busy === 1'b1) ? 1 : 0;
      while (keys_valid !== 1'b1 && lat < 200) begin
         if (lat == poke_at) begin
            start = 1'b1;
            key   = '0;
         end
         @(posedge clk);
         #1;
         start = 1'b0;
         lat++;
         if (busy === 1'b1 && keys_valid !== 1'b1) busy_n++;
      end
   endtask

   logic [127:0] v;
   int lat, busy_n;

   initial begin
      reset  = 1'b1;
      start  = 1'b0;
      key    = '0;
      rk_idx = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", 128'(busy), 128'(0));
      check("reset_valid", 128'(keys_valid), 128'(0));
      read_rk(0, v);  check("reset_rk0", v, '0);
      read_rk(10, v); check("reset_rk10", v, '0);
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("idle_busy", 128'(busy), 128'(0));

      // FIPS-197 key schedule
      accept(KEY_A);
      check("a_busy_at_accept", 128'(busy), 128'(1));
      run_to_done(0, lat, busy_n);
      check("a_latency", 128'(lat), 128'(LAT));
      check("a_busy_cycles", 128'(busy_n), 128'(LAT - 1));
      check("a_busy_after", 128'(busy), 128'(0));
      read_rk(0, v);  check("a_rk0", v, KEY_A);
      read_rk(1, v);  check("a_rk1", v, A_RK1);
      read_rk(2, v);  check("a_rk2", v, A_RK2);
      read_rk(10, v); check("a_rk10", v, A_RK10);
      for (int i = 11; i < 16; i++) begin
         read_rk(i, v);
         check($sformatf("oob_rk%0d", i), v, '0);
      end
      repeat (5) @(posedge clk);
      #1;
      read_rk(10, v); check("a_rk10_stable", v, A_RK10);
      check("a_valid_stable", 128'(keys_valid), 128'(1));

      // Restart from DONE with the second vector
      accept(KEY_B);
      check("b_valid_at_accept", 128'(keys_valid), 128'(0));
      check("b_busy_at_accept", 128'(busy), 128'(1));
      run_to_done(0, lat, busy_n);
      check("b_latency", 128'(lat), 128'(LAT));
      read_rk(0, v);  check("b_rk0", v, KEY_B);
      read_rk(1, v);  check("b_rk1", v, B_RK1);
      read_rk(10, v); check("b_rk10", v, B_RK10);

      // Start pulse during expansion is ignored
      accept(KEY_A);
      run_to_done(5, lat, busy_n);
      check("ign_latency", 128'(lat), 128'(LAT));
      read_rk(0, v);  check("ign_rk0", v, KEY_A);
      read_rk(10, v); check("ign_rk10", v, A_RK10);

      // Asynchronous reset in the middle of expansion
      accept(KEY_B);
      repeat (4) @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check("abort_busy", 128'(busy), 128'(0));
      check("abort_valid", 128'(keys_valid), 128'(0));
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int i = 0; i <= 10; i++) begin
         read_rk(i, v);
         check($sformatf("abort_rk%0d", i), v, '0);
      end
      repeat (25) @(posedge clk);
      #1;
      check("idle_after_abort_busy", 128'(busy), 128'(0));
      check("idle_after_abort_valid", 128'(keys_valid), 128'(0));

      // Fresh expansion after the abort
      accept(KEY_B);
      run_to_done(0, lat, busy_n);
      check("post_latency", 128'(lat), 128'(LAT));
      read_rk(10, v); check("post_rk10", v, B_RK10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
